sprite_fetch: RTL and testbench
===============================

Name: sprite_fetch

Overview:
- Sprite pattern fetch stage between the OAM evaluator and the 8-entry sprite shifter set.
- During PPU cycles 256-319 it reads the 8 secondary-OAM entries that the evaluator presents on its OAM bus.
- For each entry it fetches both pattern planes from CHR memory and applies vertical and horizontal flip.
- It then shifts one 27-bit sprite record into the shifter set per sprite, slot 0 first, so slot 0 ends in shifter 0.

Parameters:
- CHR_AW, 13: CHR address width; the pattern address uses the low 13 bits, and upper bits are driven 0.
- CLEAR_EMPTY, 1: when 1, an empty slot loads transparent pattern bytes (0x00); when 0, the fetched bytes are loaded unchanged.

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ce  in  1  PPU clock enable; all state advances only when i_ce=1
- i_sprites_enabled  in  1  sprite rendering enable
- i_obj_size  in  1  0 = 8x8 sprites, 1 = 8x16 sprites
- i_pat_table  in  1  sprite pattern table select for 8x8 mode (PPUCTRL bit 3)
- i_cycle  in  9  current PPU cycle
- i_oam_bus  in  8  secondary-OAM byte from the evaluator for the current cycle
- o_chr_rd  out  1  CHR read strobe
- o_chr_addr  out  CHR_AW  CHR read address
- i_chr_data  in  8  CHR read data, valid on the ce-cycle after o_chr_rd
- o_load  out  4  shifter load mask; 4'b1111 pulse = shift in one record
- o_load_in  out  27  record {pix1[7:0], pix2[7:0], x[7:0], pal[1:0], prio}
- o_busy  out  1  high while in FETCH

Behaviour:
- Reset values (async, i_rst_n=0): state=IDLE, o_chr_rd=0, o_chr_addr=0, o_load=0, o_load_in=0, o_busy=0, slot=0, all latches 0.
- States:
  - IDLE -> FETCH when i_ce, i_sprites_enabled, and i_cycle==256.
  - FETCH -> DONE after the slot-7 load (cycle 319).
  - DONE -> IDLE when i_cycle==0.
  - Any state -> IDLE on the first ce-cycle with i_sprites_enabled=0. Entering IDLE this way issues no further reads or loads and leaves the shifter contents untouched.
- FETCH phase is i_cycle[2:0]; slot = i_cycle[5:3]. All actions below occur only on ce-cycles:
  - ph0: latch row = i_oam_bus. Slot is empty if row[7:4]!=0 (0xFF fill).
  - ph1: latch tile.
  - ph2: latch attr; vflip=attr[7], hflip=attr[6], prio=attr[5], pal=attr[1:0].
  - ph3: latch x = i_oam_bus.
  - ph4: o_chr_rd=1, o_chr_addr = base with plane bit 0.
  - ph5: capture lo = i_chr_data; o_chr_rd=1, plane bit 1.
  - ph6: capture hi = i_chr_data; o_chr_rd=0.
  - ph7: o_load=4'b1111 for exactly this ce-cycle, o_load_in = {P(lo), P(hi), x, pal, prio}.
  - o_load is 0 on every other ce-cycle.
- Effective row r:
  - 8x8: r = vflip ? 7-row[2:0] : row[2:0].
  - 8x16: r = vflip ? 15-row[3:0] : row[3:0].
- Address, 13-bit {table, tileidx[7:0], plane, r[2:0]}:
  - 8x8: table = i_pat_table, tileidx = tile.
  - 8x16: table = tile[0], tileidx = {tile[7:1], r[3]}.
- P(b): the leftmost pixel must land in bit 0, because the shifter emits bit 0 first.
  - hflip=0: P(b) = bit-reverse(b).
  - hflip=1: P(b) = b.
  - Empty slot with CLEAR_EMPTY=1: P(b) = 0x00. The read is still issued, and x, pal, and prio are loaded unchanged.
- i_obj_size and i_pat_table are sampled at ph4 of each slot.
- Latency: a record appears 7 ce-cycles after its ph0 byte; exactly 8 loads per enabled line.
- Cycles outside 256-319 never produce reads or loads.
- i_ce=0 freezes all outputs and state; o_load must not repeat while ce is low.

Test Plan:
- 8x8, i_pat_table=1, slot0 bytes {0x03, 0x42, 0x01, 0x80}, CHR returns lo=0x81, hi=0x0F:
  - Addresses 0x1423, then 0x142B.
  - At cycle 263: o_load=1111, o_load_in={0x81, 0xF0, 0x80, 2'b01, 0}.
- Same slot, attr=0xC2 (vflip, hflip, pal=2, prio=0), row=0x02:
  - Address row bits = 5.
  - pix bytes unreversed: {0x81, 0x0F, x, 2'b10, 0}.
- 8x16, tile=0x25, row=0x0A, vflip=1:
  - r=5, table=1, tileidx=0x24.
  - Low-plane address 0x1245.
- Slots 3-7 filled with 0xFF:
  - 8 loads total.
  - Slots 3-7 have pix bytes = 0x00 and x=0xFF.
  - o_busy high for cycles 256-319.
- i_sprites_enabled dropped at cycle 280:
  - No o_chr_rd or o_load after that ce-cycle.
  - State IDLE.
- i_rst_n low at cycle 290:
  - Outputs zero immediately (asynchronous).
  - After release mid-window, no activity until the next cycle 256.
  - i_ce held low for 3 clocks at ph7 gives a single load pulse.

Source files
------------

// File: rtl/sprite_fetch.sv
// Sprite pattern fetch stage: during PPU cycles 256-319 walks the 8 secondary-OAM
// slots, fetches both pattern planes for each from CHR, applies flips, and
// pushes one 27-bit record per slot into the sprite shifter set.
module sprite_fetch #(
  parameter int CHR_AW      = 13,
  parameter bit CLEAR_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_sprites_enabled,
  input  logic              i_obj_size,
  input  logic              i_pat_table,
  input  logic [8:0]        i_cycle,
  input  logic [7:0]        i_oam_bus,
  output logic              o_chr_rd,
  output logic [CHR_AW-1:0] o_chr_addr,
  input  logic [7:0]        i_chr_data,
  output logic [3:0]        o_load,
  output logic [26:0]       o_load_in,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e state_q, state_d;

  logic [7:0]        row_q, tile_q, attr_q, x_q, lo_q, hi_q;
  logic              empty_q;
  logic              chr_rd_q;
  logic [CHR_AW-1:0] chr_addr_q;
  logic [3:0]        load_q;
  logic [26:0]       load_in_q;

  logic [2:0]  phase;
  logic        in_win;
  logic        act;
  logic [2:0]  r8;
  logic [3:0]  r16;
  logic [12:0] base;

  assign phase  = i_cycle[2:0];
  // cycles 256..319 share the top three bits 3'b100
  assign in_win = (i_cycle[8:6] == 3'b100);
  // Fetch actions run on ce-cycles inside the window; the cycle-256 edge that
  // starts FETCH also performs slot 0's row latch.
  assign act = i_ce && i_sprites_enabled && in_win &&
               ((state_q == FETCH) || (state_q == IDLE && i_cycle == 9'd256));

  // Leftmost pixel must end in bit 0 because the shifter emits bit 0 first.
  function automatic logic [7:0] pix(input logic [7:0] b, input logic hflip,
                                     input logic empty);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    if (empty && CLEAR_EMPTY) pix = 8'h00;
    else if (hflip)           pix = b;
    else                      pix = r;
  endfunction

  // Pattern address for the current slot (plane bit 0); size and table are
  // taken live because they are only consumed at ph4.
  always_comb begin
    r8  = attr_q[7] ? ~row_q[2:0] : row_q[2:0];
    r16 = attr_q[7] ? ~row_q[3:0] : row_q[3:0];
    if (i_obj_size) base = {tile_q[0], tile_q[7:1], r16[3], 1'b0, r16[2:0]};
    else            base = {i_pat_table, tile_q, 1'b0, r8};
  end

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: disabling sprites on any ce-cycle drops straight to IDLE
  always_comb begin
    state_d = state_q;
    if (i_ce) begin
      if (!i_sprites_enabled) state_d = IDLE;
      else begin
        unique case (state_q)
          IDLE:    if (i_cycle == 9'd256) state_d = FETCH;
          FETCH:   if (!in_win || i_cycle == 9'd319) state_d = DONE;
          DONE:    if (i_cycle == 9'd0) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // FSM outputs
  always_comb begin
    o_busy = (state_q == FETCH);
  end

  // Per-phase latches, CHR strobes and shifter load; everything holds while ce=0
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q      <= '0;
      tile_q     <= '0;
      attr_q     <= '0;
      x_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      empty_q    <= 1'b0;
      chr_rd_q   <= 1'b0;
      chr_addr_q <= '0;
      load_q     <= '0;
      load_in_q  <= '0;
    end else if (i_ce) begin
      chr_rd_q <= 1'b0;
      load_q   <= 4'h0;
      if (act) begin
        unique case (phase)
          3'd0: begin
            row_q   <= i_oam_bus;
            empty_q <= |i_oam_bus[7:4];
          end
          3'd1: tile_q <= i_oam_bus;
          3'd2: attr_q <= i_oam_bus;
          3'd3: x_q    <= i_oam_bus;
          3'd4: begin
            chr_rd_q   <= 1'b1;
            chr_addr_q <= CHR_AW'(base);
          end
          3'd5: begin
            lo_q          <= i_chr_data;
            chr_rd_q      <= 1'b1;
            chr_addr_q[3] <= 1'b1;
          end
          3'd6: hi_q <= i_chr_data;
          3'd7: begin
            load_q    <= 4'hF;
            load_in_q <= {pix(lo_q, attr_q[6], empty_q), pix(hi_q, attr_q[6], empty_q),
                          x_q, attr_q[1:0], attr_q[5]};
          end
          default: ;
        endcase
      end
    end
  end

  assign o_chr_rd   = chr_rd_q;
  assign o_chr_addr = chr_addr_q;
  assign o_load     = load_q;
  assign o_load_in  = load_in_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: drives whole scanlines, collects what the shifter
// would see, and compares against a model computed from the fetch rules.
module tb_sprite_fetch;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ce = 1'b0;
  logic        i_sprites_enabled = 1'b1;
  logic        i_obj_size = 1'b0;
  logic        i_pat_table = 1'b0;
  logic [8:0]  i_cycle = '0;
  logic [7:0]  i_oam_bus = '0;
  logic        o_chr_rd;
  logic [12:0] o_chr_addr;
  logic [7:0]  i_chr_data;
  logic [3:0]  o_load;
  logic [26:0] o_load_in;
  logic        o_busy;

  int errs = 0;
  int nchk = 0;

  logic [7:0]  chr [0:8191];
  logic [7:0]  oam [0:7][0:3];
  logic [26:0] ld_q[$];
  int          ld_cyc[$];
  logic [12:0] rd_q[$];
  int          rd_cyc[$];

  sprite_fetch #(.CHR_AW(13), .CLEAR_EMPTY(1'b1)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_ce(i_ce),
    .i_sprites_enabled(i_sprites_enabled), .i_obj_size(i_obj_size),
    .i_pat_table(i_pat_table), .i_cycle(i_cycle), .i_oam_bus(i_oam_bus),
    .o_chr_rd(o_chr_rd), .o_chr_addr(o_chr_addr), .i_chr_data(i_chr_data),
    .o_load(o_load), .o_load_in(o_load_in), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  assign i_chr_data = chr[o_chr_addr];

  // ---------------- reference model ----------------
  function automatic int eff_row(input int s);
    int row, vf;
    row = oam[s][0];
    vf  = oam[s][2][7];
    if (i_obj_size) return vf ? 15 - (row % 16) : row % 16;
    else            return vf ? 7 - (row % 8) : row % 8;
  endfunction

  function automatic int exp_addr(input int s, input int plane);
    int r, tbl, idx;
    r = eff_row(s);
    if (i_obj_size) begin
      tbl = oam[s][1] % 2;
      idx = (oam[s][1] / 2) * 2 + r / 8;
    end else begin
      tbl = i_pat_table;
      idx = oam[s][1];
    end
    return tbl * 4096 + idx * 16 + plane * 8 + r % 8;
  endfunction

  function automatic logic [7:0] exp_pix(input int s, input logic [7:0] b);
    logic [7:0] r;
    if (oam[s][0] >= 16) return 8'h00;
    if (oam[s][2][6])    return b;
    r = 8'h00;
    for (int i = 0; i < 8; i++) if (b[i]) r = r + 8'(1 << (7 - i));
    return r;
  endfunction

  function automatic logic [26:0] exp_rec(input int s);
    logic [7:0] lo, hi;
    lo = chr[exp_addr(s, 0)];
    hi = chr[exp_addr(s, 1)];
    return {exp_pix(s, lo), exp_pix(s, hi), oam[s][3], oam[s][2][1:0], oam[s][2][5]};
  endfunction

  // ---------------- drivers ----------------
  task automatic rand_oam();
    for (int s = 0; s < 8; s++) begin
      if ($urandom_range(0, 5) == 0) for (int p = 0; p < 4; p++) oam[s][p] = 8'hFF;
      else begin
        oam[s][0] = 8'($urandom_range(0, 15));
        for (int p = 1; p < 4; p++) oam[s][p] = 8'($urandom);
      end
    end
  endtask

  // One clock; on ce clocks record what the shifter/CHR would see at this edge,
  // on non-ce clocks require all outputs to hold.
  task automatic tick(input bit ce, input int c, input int lim);
    logic [45:0] snap;
    logic        eb;
    i_ce = ce;
    snap = {o_load, o_load_in, o_chr_rd, o_chr_addr, o_busy};
    if (ce) begin
      eb = (c >= 257 && c <= 319 && c <= lim);
      nchk++;
      if (o_busy !== eb) begin
        errs++; $display("FAIL busy cyc=%0d got=%b want=%b", c, o_busy, eb);
      end
      nchk++;
      if (o_load !== 4'h0 && o_load !== 4'hF) begin
        errs++; $display("FAIL load_mask cyc=%0d got=%h want=0 or f", c, o_load);
      end
      if (o_load === 4'hF) begin ld_q.push_back(o_load_in); ld_cyc.push_back(c); end
      if (o_chr_rd === 1'b1) begin rd_q.push_back(o_chr_addr); rd_cyc.push_back(c); end
    end
    @(posedge clk); @(negedge clk);
    if (!ce) begin
      nchk++;
      if ({o_load, o_load_in, o_chr_rd, o_chr_addr, o_busy} !== snap) begin
        errs++; $display("FAIL freeze cyc=%0d got=%h want=%h", c,
                         {o_load, o_load_in, o_chr_rd, o_chr_addr, o_busy}, snap);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    nchk++;
    if ({o_load, o_load_in, o_chr_rd, o_chr_addr, o_busy} !== 46'd0) begin
      errs++; $display("FAIL %s outputs got=%h want=0", tag,
                       {o_load, o_load_in, o_chr_rd, o_chr_addr, o_busy});
    end
  endtask

  // Drive cycles 0..340. stop = cycle where sprites are disabled (or reset hits
  // when rst_mode); events at edge c are observable only while c <= lim.
  task automatic run_line(input int stop, input bit rst_mode, input bit gaps);
    int lim, n;
    lim = stop - (rst_mode ? 1 : 0);
    ld_q.delete(); ld_cyc.delete(); rd_q.delete(); rd_cyc.delete();
    i_sprites_enabled = 1'b1;
    for (int c = 0; c < 341; c++) begin
      i_cycle = 9'(c);
      if (c >= 256 && c < 320 && c % 8 < 4) i_oam_bus = oam[(c - 256) / 8][c % 8];
      else                                  i_oam_bus = 8'($urandom);
      if (!rst_mode && c >= stop) i_sprites_enabled = 1'b0;
      if (rst_mode && c == stop) begin
        i_rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
        i_rst_n = 1'b1;
      end
      if (gaps) begin
        n = (c >= 256 && c <= 320 && c % 8 == 0) ? 3 : $urandom_range(0, 1);
        for (int k = 0; k < n; k++) tick(1'b0, c, lim);
      end
      tick(1'b1, c, lim);
    end
    i_sprites_enabled = 1'b1;
  endtask

  task automatic check_line(input string tag, input int stop, input bit rst_mode);
    int lim, nl, nr, ea;
    logic [26:0] er;
    lim = stop - (rst_mode ? 1 : 0);
    nl = 0; nr = 0;
    for (int s = 0; s < 8; s++) begin
      if (256 + 8 * s + 8 <= lim) nl++;
      if (256 + 8 * s + 5 <= lim) nr++;
      if (256 + 8 * s + 6 <= lim) nr++;
    end
    nchk++;
    if (ld_q.size() != nl) begin
      errs++; $display("FAIL %s load_count got=%0d want=%0d", tag, ld_q.size(), nl);
    end
    nchk++;
    if (rd_q.size() != nr) begin
      errs++; $display("FAIL %s read_count got=%0d want=%0d", tag, rd_q.size(), nr);
    end
    for (int i = 0; i < nl && i < ld_q.size(); i++) begin
      er = exp_rec(i);
      nchk++;
      if (ld_q[i] !== er || ld_cyc[i] != 256 + 8 * i + 8) begin
        errs++; $display("FAIL %s load%0d got=%h@%0d want=%h@%0d", tag, i, ld_q[i],
                         ld_cyc[i], er, 256 + 8 * i + 8);
      end
    end
    for (int i = 0; i < nr && i < rd_q.size(); i++) begin
      ea = exp_addr(i / 2, i % 2);
      nchk++;
      if (rd_q[i] !== 13'(ea) || rd_cyc[i] != 256 + 8 * (i / 2) + 5 + i % 2) begin
        errs++; $display("FAIL %s read%0d got=%h@%0d want=%h@%0d", tag, i, rd_q[i],
                         rd_cyc[i], ea, 256 + 8 * (i / 2) + 5 + i % 2);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    i_rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset_idle");
  endtask

  task automatic test_basic_8x8();
    rand_oam();
    oam[0][0] = 8'h03; oam[0][1] = 8'h42; oam[0][2] = 8'h01; oam[0][3] = 8'h80;
    chr[13'h1423] = 8'h81; chr[13'h142B] = 8'h0F;
    i_obj_size = 1'b0; i_pat_table = 1'b1;
    run_line(1000, 1'b0, 1'b0);
    check_line("basic", 1000, 1'b0);
    nchk++;
    if (rd_q.size() < 2 || rd_q[0] !== 13'h1423 || rd_q[1] !== 13'h142B) begin
      errs++; $display("FAIL basic_addr got=%h,%h want=1423,142b",
                       rd_q.size() > 0 ? rd_q[0] : 13'h0, rd_q.size() > 1 ? rd_q[1] : 13'h0);
    end
    nchk++;
    if (ld_q.size() < 1 || ld_q[0] !== {8'h81, 8'hF0, 8'h80, 2'b01, 1'b0}) begin
      errs++; $display("FAIL basic_rec got=%h want=%h", ld_q.size() > 0 ? ld_q[0] : 27'h0,
                       {8'h81, 8'hF0, 8'h80, 2'b01, 1'b0});
    end
  endtask

  task automatic test_flip();
    rand_oam();
    oam[0][0] = 8'h02; oam[0][1] = 8'h42; oam[0][2] = 8'hC2; oam[0][3] = 8'h33;
    chr[13'h1425] = 8'h81; chr[13'h142D] = 8'h0F;
    i_obj_size = 1'b0; i_pat_table = 1'b1;
    run_line(1000, 1'b0, 1'b0);
    check_line("flip", 1000, 1'b0);
    nchk++;
    if (rd_q.size() < 1 || rd_q[0][2:0] !== 3'd5) begin
      errs++; $display("FAIL flip_row got=%0d want=5", rd_q.size() > 0 ? rd_q[0][2:0] : 3'd0);
    end
    nchk++;
    if (ld_q.size() < 1 || ld_q[0] !== {8'h81, 8'h0F, 8'h33, 2'b10, 1'b0}) begin
      errs++; $display("FAIL flip_rec got=%h want=%h", ld_q.size() > 0 ? ld_q[0] : 27'h0,
                       {8'h81, 8'h0F, 8'h33, 2'b10, 1'b0});
    end
  endtask

  task automatic test_8x16();
    rand_oam();
    oam[0][0] = 8'h0A; oam[0][1] = 8'h25; oam[0][2] = 8'h80; oam[0][3] = 8'h10;
    i_obj_size = 1'b1; i_pat_table = 1'b0;
    run_line(1000, 1'b0, 1'b0);
    check_line("tall", 1000, 1'b0);
    nchk++;
    if (rd_q.size() < 1 || rd_q[0] !== 13'h1245) begin
      errs++; $display("FAIL tall_addr got=%h want=1245", rd_q.size() > 0 ? rd_q[0] : 13'h0);
    end
  endtask

  task automatic test_empty();
    rand_oam();
    for (int s = 0; s < 3; s++) oam[s][0] = 8'($urandom_range(0, 7));
    for (int s = 3; s < 8; s++) for (int p = 0; p < 4; p++) oam[s][p] = 8'hFF;
    i_obj_size = 1'b0; i_pat_table = 1'b0;
    run_line(1000, 1'b0, 1'b0);
    check_line("empty", 1000, 1'b0);
    for (int s = 3; s < 8 && s < ld_q.size(); s++) begin
      nchk++;
      if (ld_q[s][26:11] !== 16'h0 || ld_q[s][10:3] !== 8'hFF) begin
        errs++; $display("FAIL empty_slot%0d got=%h want=pix 0 x ff", s, ld_q[s]);
      end
    end
  endtask

  task automatic test_disable();
    rand_oam();
    i_obj_size = 1'b0; i_pat_table = 1'b1;
    run_line(280, 1'b0, 1'b0);
    check_line("disable", 280, 1'b0);
    nchk++;
    if (o_busy !== 1'b0 || o_load !== 4'h0 || o_chr_rd !== 1'b0) begin
      errs++; $display("FAIL disable_idle got busy=%b load=%h rd=%b want 0", o_busy, o_load, o_chr_rd);
    end
  endtask

  task automatic test_reset_mid();
    rand_oam();
    i_obj_size = 1'b0; i_pat_table = 1'b0;
    run_line(290, 1'b1, 1'b1);
    check_line("reset_mid", 290, 1'b1);
    rand_oam();
    run_line(1000, 1'b0, 1'b1);
    check_line("after_reset", 1000, 1'b0);
  endtask

  task automatic test_random_gaps();
    for (int l = 0; l < 3; l++) begin
      rand_oam();
      i_obj_size = 1'($urandom); i_pat_table = 1'($urandom);
      run_line(1000, 1'b0, 1'b1);
      check_line("rand_gaps", 1000, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int l = 0; l < 2; l++) begin
      rand_oam();
      i_obj_size = 1'($urandom); i_pat_table = 1'($urandom);
      run_line(1000, 1'b0, 1'b0);
      check_line("b2b", 1000, 1'b0);
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) chr[a] = 8'($urandom);
    test_reset();
    test_basic_8x8();
    test_flip();
    test_8x16();
    test_empty();
    test_disable();
    test_reset_mid();
    test_random_gaps();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
